imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the instruction-memory address width.
REQ-002 The block SHALL have parameter IW_W, default 16, giving the instruction-word width, fixed at two bytes.
REQ-003 The block SHALL have port clk, input, 1, the single clock.
REQ-004 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a single-cycle request to begin a load.
REQ-006 The block SHALL have port in_data, input, 8, the byte stream from the host.
REQ-007 The block SHALL have port in_valid, input, 1, asserted when in_data holds a byte.
REQ-008 The block SHALL have port in_ready, output, 1; a byte is accepted on a cycle where in_valid and in_ready are both high.
REQ-009 The block SHALL have port wr_en, output, 1, the instruction-memory write strobe.
REQ-010 The block SHALL have port wr_addr, output, ADDR_W, the instruction-memory write address.
REQ-011 The block SHALL have port wr_data, output, IW_W, the instruction-memory write word.
REQ-012 The block SHALL have port cpu_hold, output, 1, which holds the CPU PC in reset while high.
REQ-013 The block SHALL have port done, output, 1, a level indicating that the load succeeded.
REQ-014 The block SHALL have port err, output, 1, a level indicating that the load failed.

Function
REQ-015 The stream format SHALL be: count byte N, then 2N data bytes with the high byte first for each word, then one checksum byte.
REQ-016 The FSM SHALL have states IDLE, COUNT, HI, LO, CHECK, DONE and ERROR.
REQ-017 In IDLE, DONE or ERROR, a start pulse SHALL cause all of the following on the next cycle:
- state becomes COUNT;
- cpu_hold goes to 1;
- done and err go to 0;
- the word counter and the checksum clear to 0.
REQ-018 A start pulse while in COUNT, HI, LO or CHECK SHALL be ignored.
REQ-019 in_ready SHALL be 1 exactly in COUNT, HI, LO and CHECK, and 0 in IDLE, DONE and ERROR.
REQ-020 COUNT SHALL capture N on handshake; N=0 SHALL go to ERROR, and any other value SHALL go to HI.
REQ-021 HI SHALL latch the byte on handshake, XOR it into the checksum, and go to LO.
REQ-022 LO, on handshake, SHALL do all of the following:
- XOR the byte into the checksum;
- on the next cycle, drive wr_en=1 for exactly one cycle with wr_addr equal to the word counter and wr_data={hi,lo};
- then increment the counter.
REQ-023 After the LO handshake, the next state SHALL be CHECK if the counter has reached N-1, and HI otherwise.
REQ-024 Addresses SHALL run from 0 to N-1; with N at most 255, the address SHALL never wrap.
REQ-025 CHECK SHALL go to DONE on a handshake byte equal to the accumulated checksum, and to ERROR otherwise.
REQ-026 DONE SHALL hold done=1 and cpu_hold=0 until the next start.
REQ-027 ERROR SHALL hold err=1 and cpu_hold=1 until the next start; a retry after start SHALL restart at address 0.
REQ-028 The block SHALL never accept or drop bytes while in_valid is low, and stalls of any length SHALL be tolerated in every receiving state.
REQ-029 wr_addr and wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-030 While reset is high at a clk edge, the following SHALL all be 0 on the next cycle:
- state, which becomes IDLE;
- in_ready, wr_en, wr_addr, wr_data;
- cpu_hold, done, err;
- the counter and the checksum.
REQ-031 A reset in mid-load SHALL abandon the load without erasing words already written, and the host SHALL resend from the count byte.

Structure
REQ-032 A shared package SHALL hold the state enumeration, the BYTE_W=8 constant, and the ADDR_W and IW_W defaults.
REQ-033 The checksum accumulator SHALL be a sub-module named xor_accum, with ports clear, enable and 8-bit byte, and an 8-bit sum output.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 The bench SHALL cover a basic load: start, then bytes 02,12,34,AB,CD,40 -> writes 0x1234@0 and 0xABCD@1, then done=1, cpu_hold=0.
REQ-036 The bench SHALL cover a bad checksum: the same stream with a final byte of 41 -> err=1, cpu_hold=1, done=0, and exactly 2 writes.
REQ-037 The bench SHALL cover N=0: start, then 00 -> err=1 and no wr_en.
REQ-038 The bench SHALL cover backpressure gaps: the basic load with in_valid low for 3 cycles between every byte -> identical writes and done=1.
REQ-039 The bench SHALL cover reset mid-load: reset after the byte AB -> all outputs 0; a subsequent start and the full stream -> done=1.
REQ-040 The bench SHALL cover a start during a load: a start pulse in HI -> no effect; after ERROR, a start and a valid stream -> err=0, done=1, and writes beginning at address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int IW_W_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    function automatic logic is_receiving(input state_t s);
        return (s == ST_COUNT) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_xor_accum.sv
// Running XOR checksum over the payload bytes of one load.
module xor_accum
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] sum
);

    logic [BYTE_W-1:0] sum_q;
    logic [BYTE_W-1:0] sum_d;

    // NOTE: the default assignment first keeps this combinational block latch-free.
    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (enable) begin
            sum_d = sum_q ^ in_byte;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader: count, 2N big-endian word bytes, XOR checksum; writes IMEM and holds the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int IW_W   = IW_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [IW_W-1:0]   wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] n_q, n_d;
    logic [BYTE_W-1:0] cnt_q, cnt_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [IW_W-1:0]   wr_data_q, wr_data_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              acc_clear;
    logic              acc_en;
    logic [BYTE_W-1:0] acc_sum;
    logic              hs;

    // in_ready is registered, so the handshake uses the value the host actually sees.
    assign hs = in_valid && in_ready_q;

    xor_accum u_xor_accum (
        .clk     (clk),
        .reset   (reset),
        .clear   (acc_clear),
        .enable  (acc_en),
        .in_byte (in_data),
        .sum     (acc_sum)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        acc_clear = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_COUNT;
                    cnt_d     = '0;
                    acc_clear = 1'b1;
                end
            end
            ST_COUNT: begin
                if (hs) begin
                    n_d     = in_data;
                    state_d = (in_data == '0) ? ST_ERROR : ST_HI;
                end
            end
            ST_HI: begin
                if (hs) begin
                    hi_d    = in_data;
                    acc_en  = 1'b1;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (hs) begin
                    acc_en    = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = ADDR_W'(cnt_q);
                    wr_data_d = IW_W'({hi_q, in_data});
                    cnt_d     = cnt_q + 1'b1;
                    state_d   = (cnt_q == n_q - 1'b1) ? ST_CHECK : ST_HI;
                end
            end
            ST_CHECK: begin
                if (hs) begin
                    state_d = (in_data == acc_sum) ? ST_DONE : ST_ERROR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies decoded from the next state.
        in_ready_d = is_receiving(state_d);
        cpu_hold_d = is_receiving(state_d) || (state_d == ST_ERROR);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
